// File: rtl/ref_win_buf_if.sv
// Bus bundle between the reference memory controller, the window buffer
// and the PE array. The master side drives rows and consumes windows;
// the slave side is the window buffer itself.
interface ref_win_buf_if #(
  parameter int BANKS    = 32,
  parameter int PIX_W    = 8,
  parameter int WIN_ROWS = 4
) ();
  logic                            start;
  logic [BANKS*PIX_W-1:0]          rd_data_all;
  logic                            rd_valid;
  logic                            in_ready;
  logic [WIN_ROWS*BANKS*PIX_W-1:0] win_data;
  logic                            win_valid;
  logic                            pe_ready;
  logic [6:0]                      row_cnt;
  logic                            sweep_done;

  modport master (
    output start, rd_data_all, rd_valid, pe_ready,
    input  in_ready, win_data, win_valid, row_cnt, sweep_done
  );

  modport slave (
    input  start, rd_data_all, rd_valid, pe_ready,
    output in_ready, win_data, win_valid, row_cnt, sweep_done
  );
endinterface

// File: rtl/ref_win_buf.sv
// Sliding reference-window buffer: stacks the most recent WIN_ROWS rows
// from the reference banks and hands the window to the PE array, sliding
// down one row per consumed search point.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | waiting for start, no rows accepted
// S_FILL   | collecting the first WIN_ROWS rows of a sweep
// S_HOLD   | full window presented; in_ready follows pe_ready
// S_REFILL | window consumed without a new row, waiting for one row
// S_DONE   | one-cycle sweep_done pulse, then back to idle
module ref_win_buf #(
  parameter int BANKS      = 32,
  parameter int PIX_W      = 8,
  parameter int WIN_ROWS   = 4,
  parameter int SWEEP_ROWS = 96
) (
  input  logic         i_clk,
  input  logic         i_rst,
  ref_win_buf_if.slave bus
);
  localparam int          ROW_W   = BANKS * PIX_W;
  localparam int          WIN_W   = WIN_ROWS * ROW_W;
  localparam logic [6:0]  L_SWEEP = 7'(SWEEP_ROWS);
  localparam logic [3:0]  L_WIN   = 4'(WIN_ROWS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_HOLD,
    S_REFILL,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIN_W-1:0] r_win;
  logic             r_win_valid;
  logic             r_sweep_done;
  logic [6:0]       r_row_cnt;
  logic [3:0]       r_fill_left;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_consume;
  logic [WIN_W-1:0] w_win_shift;

  // Readiness for a new row; only in HOLD does it depend on pe_ready, so
  // a row is only taken there when the current window leaves on the same edge.
  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      S_FILL, S_REFILL: w_in_ready = 1'b1;
      S_HOLD:           w_in_ready = bus.pe_ready && (r_row_cnt < L_SWEEP);
      default:          w_in_ready = 1'b0;
    endcase
  end

  assign w_accept    = bus.rd_valid && w_in_ready;
  assign w_consume   = r_win_valid && bus.pe_ready;
  // Oldest row drops out of the bottom, the new row enters at the top.
  assign w_win_shift = {bus.rd_data_all, r_win[WIN_W-1:ROW_W]};

  // Sequencer: window shift, row counting and registered handshake outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_win        <= '0;
      r_win_valid  <= 1'b0;
      r_sweep_done <= 1'b0;
      r_row_cnt    <= '0;
      r_fill_left  <= L_WIN;
    end else if (bus.start) begin
      // start wins over any accept or consume on this edge
      r_state      <= S_FILL;
      r_win        <= '0;
      r_win_valid  <= 1'b0;
      r_sweep_done <= 1'b0;
      r_row_cnt    <= '0;
      r_fill_left  <= L_WIN;
    end else begin
      r_sweep_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_win_valid <= 1'b0;
        end
        S_FILL: begin
          if (w_accept) begin
            r_win       <= w_win_shift;
            r_row_cnt   <= r_row_cnt + 7'd1;
            r_fill_left <= r_fill_left - 4'd1;
            if (r_fill_left == 4'd1) begin
              r_state     <= S_HOLD;
              r_win_valid <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (w_consume) begin
            if (w_accept) begin
              r_win     <= w_win_shift;
              r_row_cnt <= r_row_cnt + 7'd1;
            end else begin
              r_win_valid <= 1'b0;
              if (r_row_cnt == L_SWEEP) begin
                r_state      <= S_DONE;
                r_sweep_done <= 1'b1;
              end else begin
                r_state <= S_REFILL;
              end
            end
          end
        end
        S_REFILL: begin
          if (w_accept) begin
            r_win       <= w_win_shift;
            r_row_cnt   <= r_row_cnt + 7'd1;
            r_state     <= S_HOLD;
            r_win_valid <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state     <= S_IDLE;
          r_win_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.win_data   = r_win;
  assign bus.win_valid  = r_win_valid;
  assign bus.row_cnt    = r_row_cnt;
  assign bus.sweep_done = r_sweep_done;
endmodule

// File: tb/tb_ref_win_buf.sv
// Bench for ref_win_buf: directed sweep scenarios followed by random traffic,
// all compared against a window/row-count model of the buffer's behaviour.
module tb_ref_win_buf;
  localparam int BANKS      = 32;
  localparam int PIX_W      = 8;
  localparam int WIN_ROWS   = 4;
  localparam int SWEEP_ROWS = 8;
  localparam int ROW_W      = BANKS * PIX_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ref_win_buf_if #(.BANKS(BANKS), .PIX_W(PIX_W), .WIN_ROWS(WIN_ROWS)) bus ();

  ref_win_buf #(
    .BANKS(BANKS), .PIX_W(PIX_W), .WIN_ROWS(WIN_ROWS), .SWEEP_ROWS(SWEEP_ROWS)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  // model: a sweep is active, the window is a list of the last rows,
  // m_need counts rows still missing before a window can be offered
  bit               m_known  = 1'b0;
  bit               m_active = 1'b0;
  logic [ROW_W-1:0] m_win[WIN_ROWS];
  int               m_cnt    = 0;
  int               m_need   = WIN_ROWS;
  bit               m_done   = 1'b0;
  bit               m_last_acc = 1'b0;

  int nvec = 0;
  int nerr = 0;

  function automatic logic [ROW_W-1:0] rowval(input int n);
    logic [7:0] b;
    b = n[7:0];
    return {BANKS{b}};
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_row(input int r, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL win_row%0d: observed %h expected %h", r, obs, exp);
    end
  endtask

  task automatic step(input logic s_rst, input logic s_start, input logic s_rv,
                      input logic [ROW_W-1:0] d, input logic s_pe);
    logic exp_ir, valid, acc, con;
    @(negedge clk);
    rst             = s_rst;
    bus.start       = s_start;
    bus.rd_valid    = s_rv;
    bus.rd_data_all = d;
    bus.pe_ready    = s_pe;
    #1;
    valid  = m_active && (m_need == 0);
    exp_ir = m_active && ((m_need > 0) || (s_pe && (m_cnt < SWEEP_ROWS)));
    if (m_known) begin
      check_bit("in_ready", bus.in_ready, exp_ir);
      check_bit("win_valid", bus.win_valid, valid);
      check_bit("sweep_done", bus.sweep_done, m_done);
      check_cnt("row_cnt", bus.row_cnt, 7'(m_cnt));
      for (int r = 0; r < WIN_ROWS; r++)
        check_row(r, bus.win_data[r*ROW_W +: ROW_W], m_win[r]);
    end
    acc = s_rv && exp_ir;
    con = valid && s_pe;
    @(posedge clk);
    m_last_acc = 1'b0;
    if (s_rst || s_start) begin
      m_known  = 1'b1;
      m_active = s_start && !s_rst;
      for (int r = 0; r < WIN_ROWS; r++) m_win[r] = '0;
      m_cnt  = 0;
      m_need = WIN_ROWS;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (acc) begin
        for (int r = 0; r < WIN_ROWS - 1; r++) m_win[r] = m_win[r+1];
        m_win[WIN_ROWS-1] = d;
        m_cnt++;
        if (m_need > 0) m_need--;
        m_last_acc = 1'b1;
      end else if (con) begin
        if (m_cnt == SWEEP_ROWS) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end else begin
          m_need = 1;
        end
      end
    end
  endtask

  // offer one row until the buffer takes it, within a cycle budget
  task automatic send_row(input logic [ROW_W-1:0] d, input logic s_pe);
    int k;
    k = 0;
    do begin
      step(1'b0, 1'b0, 1'b1, d, s_pe);
      k++;
    end while (!m_last_acc && k < 20);
    nvec++;
    assert (m_last_acc) else begin
      nerr++;
      $error("FAIL row_accept_timeout: observed no accept expected accept within 20 cycles");
    end
  endtask

  initial begin
    logic [ROW_W-1:0] rd;
    logic             r_rst, r_st, r_rv, r_pe;
    for (int r = 0; r < WIN_ROWS; r++) m_win[r] = '0;
    bus.start       = 1'b0;
    bus.rd_valid    = 1'b0;
    bus.rd_data_all = '0;
    bus.pe_ready    = 1'b0;

    // reset, then rows offered with no start are dropped
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b1, rowval(99), 1'b1);

    // fill with PE stalled
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    for (int n = 1; n <= 4; n++) send_row(rowval(n), 1'b0);

    // backpressure: row 5 offered but not taken
    repeat (5) step(1'b0, 1'b0, 1'b1, rowval(5), 1'b0);

    // full-rate remainder of the sweep, final consume, done pulse, idle
    for (int n = 5; n <= 8; n++) send_row(rowval(n), 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // bubble: consume into refill, then one row restores the window
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    for (int n = 1; n <= 4; n++) send_row(rowval(n), 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    send_row(rowval(5), 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);

    // abort at row_cnt=6 with a simultaneous row offer
    send_row(rowval(6), 1'b1);
    step(1'b0, 1'b1, 1'b1, rowval(7), 1'b1);
    send_row(rowval(11), 1'b0);
    send_row(rowval(12), 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);

    // random traffic
    repeat (800) begin
      r_rst = ($urandom_range(0, 299) == 0);
      r_st  = ($urandom_range(0, 24) == 0);
      r_rv  = ($urandom_range(0, 3) != 0);
      r_pe  = ($urandom_range(0, 3) != 0);
      for (int b = 0; b < ROW_W / 32; b++) rd[b*32 +: 32] = $urandom();
      step(r_rst, r_st, r_rv, rd, r_pe);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
